// File: rtl/shift_pkg.sv
// Shared constants for the multi-cycle shifter: operation codes, FSM encoding, default coarse step.
// Pure declarations, no logic; no flow control.
// Imported by shift_step and shift_seq_unit.
package shift_pkg;

    localparam int SHIFT_STEP = 4;

    localparam logic [1:0] SHIFT_SRL = 2'b00;
    localparam logic [1:0] SHIFT_SLL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Fixed-distance shift of one operand by AMT bits, selected by operation code.
// Latency: purely combinational.
// Backpressure: none; the output follows the inputs.
module shift_step
    import shift_pkg::*;
#(
    parameter int AMT   = 1,
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = x;
        case (mode)
            SHIFT_SRL: y = x >> AMT;
            SHIFT_SLL: y = x << AMT;
            // Arithmetic shift replicates the sign bit on every iteration.
            SHIFT_SRA: y = $signed(x) >>> AMT;
            default:   y = x;
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative SRL/SLL/SRA shifter: coarse STEP-bit steps, then single-bit steps.
// Latency: shamt/STEP + shamt%STEP + 1 cycles from the accepting edge to done.
// Backpressure: start is ignored while busy; a new start is accepted in IDLE or DONE.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = SHIFT_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   rem;
    logic [1:0]       op;

    logic [WIDTH-1:0] y_coarse;
    logic [WIDTH-1:0] y_fine;
    logic [WIDTH-1:0] step_y;
    logic [SHW-1:0]   rem_nxt;
    logic             use_coarse;
    logic             accept;

    shift_step #(.AMT(STEP), .WIDTH(WIDTH)) u_step_coarse (
        .x    (acc),
        .mode (op),
        .y    (y_coarse)
    );

    shift_step #(.AMT(1), .WIDTH(WIDTH)) u_step_fine (
        .x    (acc),
        .mode (op),
        .y    (y_fine)
    );

    assign busy   = (state == ST_SHIFT);
    assign done   = (state == ST_DONE);
    assign accept = start && !busy;

    always_comb begin
        use_coarse = (rem >= SHW'(STEP));
        step_y     = use_coarse ? y_coarse : y_fine;
        rem_nxt    = use_coarse ? (rem - SHW'(STEP)) : (rem - SHW'(1));
    end

    // result is loaded on the edge that enters DONE so it is valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            acc    <= '0;
            rem    <= '0;
            op     <= SHIFT_SRL;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        acc <= a;
                        rem <= shamt;
                        op  <= mode;
                        if (shamt == '0 || mode == SHIFT_RSV) begin
                            state  <= ST_DONE;
                            result <= (mode == SHIFT_RSV) ? '0 : a;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    acc <= step_y;
                    rem <= rem_nxt;
                    if (rem_nxt == '0) begin
                        state  <= ST_DONE;
                        result <= step_y;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed MIPS shift cases plus random ops
// compared against an arithmetic reference model.
module tb_shift_seq_unit;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hold = '0;

    always #5 clk = ~clk;

    shift_seq_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .shamt  (shamt),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] model_res(input logic [31:0] x, input int s, input logic [1:0] m);
        logic signed [31:0] sx;
        sx = x;
        case (m)
            2'b00:   return x >> s;
            2'b01:   return x << s;
            2'b10:   return sx >>> s;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input int s, input logic [1:0] m);
        if (s == 0 || m == 2'b11) return 1;
        return s / 4 + s % 4 + 1;
    endfunction

    // Drive a request at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [31:0] ia, input logic [4:0] is, input logic [1:0] im);
        a = ia; shamt = is; mode = im; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    endtask

    // Counts cycles after the accepting edge until done; optionally pulses start at cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int lat, output int busy_n,
                             output bit stable, output bit timeout);
        lat = 0; busy_n = 0; stable = 1'b1; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_n++;
            if (result !== exp_hold) stable = 1'b0;
            if (lat == pulse_at) begin
                a = $urandom; shamt = 5'($urandom); mode = 2'($urandom); start = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; shamt = '0; mode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h, required 0/0/00000000", busy, done, result);
        end
        rst = 1'b0;
        exp_hold = '0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'h8000_0000, 32'h8000_0000, 32'hF000_0000, 32'h0000_0001,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [4:0]  ts [7] = '{5'd31, 5'd4, 5'd7, 5'd5, 5'd31, 5'd0, 5'd9};
        logic [1:0]  tm [7] = '{SHIFT_SRL, SHIFT_SRA, SHIFT_SRA, SHIFT_SLL, SHIFT_SLL, SHIFT_SLL, SHIFT_RSV};
        logic [31:0] er [7] = '{32'h0000_0001, 32'hF800_0000, 32'hFFE0_0000, 32'h0000_0020,
                                32'h8000_0000, 32'h1234_5678, 32'h0000_0000};
        int          el [7] = '{11, 2, 5, 3, 11, 1, 1};
        int lat, bn;
        bit st, to;
        for (int k = 0; k < 7; k++) begin
            issue(ta[k], ts[k], tm[k]);
            wait_done(-1, lat, bn, st, to);
            n_checks++;
            if (to || result !== er[k] || lat != el[k] || bn != el[k] - 1 || !st) begin
                n_fail++;
                $display("FAIL directed[%0d]: result=%h lat=%0d busy=%0d stable=%0b timeout=%0b, required %h lat=%0d busy=%0d stable=1",
                         k, result, lat, bn, st, to, er[k], el[k], el[k] - 1);
            end
            exp_hold = er[k];
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || result !== exp_hold) begin
                n_fail++;
                $display("FAIL done_pulse[%0d]: done=%b result=%h after DONE, required 0 and %h", k, done, result, exp_hold);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bn;
        bit st, to;
        issue(32'h0000_0003, 5'd20, SHIFT_SLL);
        wait_done(2, lat, bn, st, to);
        n_checks++;
        if (to || result !== 32'h0030_0000 || lat != 6 || !st) begin
            n_fail++;
            $display("FAIL start_while_busy: result=%h lat=%0d stable=%0b timeout=%0b, required 00300000 lat=6", result, lat, st, to);
        end
        exp_hold = 32'h0030_0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int dones = 0;
        issue(32'hFFFF_0000, 5'd31, SHIFT_SRA);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: busy=%b done=%b result=%h, required 0/0/00000000", busy, done, result);
        end
        rst = 1'b0;
        exp_hold = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL stray_done: %0d done cycles after abort, required 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        bit st, to;
        issue(32'h8000_0000, 5'd4, SHIFT_SRA);
        wait_done(-1, lat, bn, st, to);
        n_checks++;
        if (to || result !== 32'hF800_0000 || lat != 2) begin
            n_fail++;
            $display("FAIL b2b_op1: result=%h lat=%0d timeout=%0b, required f8000000 lat=2", result, lat, to);
        end
        exp_hold = 32'hF800_0000;
        issue(32'h0000_0001, 5'd5, SHIFT_SLL);
        wait_done(-1, lat, bn, st, to);
        n_checks++;
        if (to || result !== 32'h0000_0020 || lat != 3 || !st) begin
            n_fail++;
            $display("FAIL b2b_op2: result=%h lat=%0d stable=%0b timeout=%0b, required 00000020 lat=3", result, lat, st, to);
        end
        exp_hold = 32'h0000_0020;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] ra, er;
        logic [4:0]  rs;
        logic [1:0]  rm;
        int lat, bn, el, gap;
        bit st, to;
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom; rs = 5'($urandom); rm = 2'($urandom);
            er = model_res(ra, int'(rs), rm);
            el = model_lat(int'(rs), rm);
            issue(ra, rs, rm);
            wait_done(-1, lat, bn, st, to);
            n_checks++;
            if (to || result !== er || lat != el || bn != el - 1 || !st) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h shamt=%0d mode=%0d: result=%h lat=%0d busy=%0d stable=%0b timeout=%0b, required %h lat=%0d",
                         k, ra, rs, rm, result, lat, bn, st, to, er, el);
            end
            exp_hold = er;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
